// File: rtl/salaga_mem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM.
// Latency: none (package only).
// Backpressure: none (package only).
package salaga_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam int CNT_W = 4;

    localparam logic [3:0] MASK_WORD    = 4'b1111;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;
    localparam logic [3:0] MASK_BYTE1   = 4'b0010;
    localparam logic [3:0] MASK_BYTE2   = 4'b0100;
    localparam logic [3:0] MASK_BYTE3   = 4'b1000;

endpackage

// File: rtl/dmem_bram.sv
// Single-port RAM, 32-bit words, per-byte write enables, registered read (read-first).
// Latency: read data valid the cycle after en_i.
// Backpressure: none; one access per cycle when en_i is high.
module dmem_bram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Processor data-memory responder: IDLE/WAIT/RESP FSM in front of a byte-write RAM.
// Latency: op_data_valid 1+WAIT_CYCLES cycles after acceptance; one request in flight.
// Backpressure: op_data_ready high only in IDLE; requests outside IDLE are dropped.
// Optional: define DMEM_BOUNDS_CHECK_EN to flag out-of-range word indices instead of wrapping.
module dmem_responder
    import salaga_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_ready,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_proc,
    output logic        op_data_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       mask_q;
    logic             wr_q;
    logic             valid_q;
    logic             rd_resp_q;

    logic             accept;
    logic             go_resp;
    logic             in_range;
    logic             cur_wr;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_mask;
    logic             ram_en;
    logic [3:0]       ram_be;
    logic [31:0]      ram_rdata;
    logic             unused_addr_bits;

    assign accept = (state_q == ST_IDLE) && (ip_data_rd || ip_data_wr);

    // With zero wait states the RAM is accessed on the acceptance edge, so
    // the request fields are taken straight from the ports in IDLE.
    assign cur_addr  = (state_q == ST_IDLE) ? ip_data_addr      : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? ip_data_from_proc : wdata_q;
    assign cur_mask  = (state_q == ST_IDLE) ? ip_data_mask      : mask_q;
    assign cur_wr    = (state_q == ST_IDLE) ? ip_data_wr        : wr_q;

    assign go_resp = (accept && (WAIT_CYCLES == 0))
                   || ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));

`ifdef DMEM_BOUNDS_CHECK_EN
    logic err_q;
    assign in_range    = (cur_addr[31:2] < 30'(DEPTH_WORDS));
    assign op_data_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= go_resp && !in_range;
        end
    end
`else
    assign in_range    = 1'b1;
    assign op_data_err = 1'b0;
`endif

    // Reset gates the RAM access so an aborted write never lands.
    assign ram_en = go_resp && !reset;
    assign ram_be = (cur_wr && in_range) ? cur_mask : 4'b0000;

    assign unused_addr_bits = ^{cur_addr[1:0], cur_addr[31:AW+2]};

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .be_i    (ram_be),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            wr_q      <= 1'b0;
            valid_q   <= 1'b0;
            rd_resp_q <= 1'b0;
        end else begin
            valid_q   <= go_resp;
            rd_resp_q <= go_resp && !cur_wr && in_range;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= ip_data_addr;
                        wdata_q <= ip_data_from_proc;
                        mask_q  <= ip_data_mask;
                        wr_q    <= ip_data_wr;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_data_ready   = (state_q == ST_IDLE);
    assign op_data_valid   = valid_q;
    assign op_data_to_proc = (valid_q && rd_resp_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=0 at index 0, =1 at index 1)
// checked against a byte-lane memory model and a response scoreboard.
module tb_dmem_responder;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_a  [2];
    logic [31:0] wdat_a  [2];
    logic [3:0]  mask_a  [2];
    logic        wr_a    [2];
    logic        rd_a    [2];
    logic        ready_a [2];
    logic        valid_a [2];
    logic        err_a   [2];
    logic [31:0] rdat_a  [2];

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] model [2][1024];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .ip_data_addr(addr_a[0]), .ip_data_wr(wr_a[0]), .ip_data_mask(mask_a[0]),
        .ip_data_from_proc(wdat_a[0]), .ip_data_rd(rd_a[0]),
        .op_data_ready(ready_a[0]), .op_data_valid(valid_a[0]),
        .op_data_to_proc(rdat_a[0]), .op_data_err(err_a[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset(reset),
        .ip_data_addr(addr_a[1]), .ip_data_wr(wr_a[1]), .ip_data_mask(mask_a[1]),
        .ip_data_from_proc(wdat_a[1]), .ip_data_rd(rd_a[1]),
        .op_data_ready(ready_a[1]), .op_data_valid(valid_a[1]),
        .op_data_to_proc(rdat_a[1]), .op_data_err(err_a[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic mon(input int k);
        exp_t e;
        if (valid_a[k]) begin
            if (qsize(k) == 0) begin
                chk($sformatf("spurious_valid[%0d]", k), 32'd1, 32'd0);
            end else begin
                if (k == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk($sformatf("resp_data[%0d]", k), rdat_a[k], e.data);
                chk($sformatf("resp_err[%0d]", k), {31'd0, err_a[k]}, {31'd0, e.err});
                chk($sformatf("resp_cycle[%0d]", k), 32'(cyc), 32'(e.due));
            end
        end else begin
            chk($sformatf("idle_data_zero[%0d]", k), rdat_a[k], 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            mon(0);
            mon(1);
        end
    end

    // Drives one request for a cycle, predicts its response from the model,
    // and optionally waits for the scoreboard to drain.
    task automatic txn(input int k, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d, input bit track, input bit drain);
        exp_t e;
        bit   oob;
        int   n;
        @(negedge clk);
        chk($sformatf("ready_before_req[%0d]", k), {31'd0, ready_a[k]}, 32'd1);
        addr_a[k] = a; wdat_a[k] = d; mask_a[k] = m; rd_a[k] = rd; wr_a[k] = wr;
        oob   = BOUNDS && (a[31:2] >= 30'd1024);
        e.due = cyc + 1 + k;
        e.err = oob;
        if (wr) begin
            e.data = 32'h0;
            if (!oob && track) begin
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) model[k][a[11:2]][8*b +: 8] = d[8*b +: 8];
                end
            end
        end else begin
            e.data = oob ? 32'h0 : model[k][a[11:2]];
        end
        if (track) begin
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        rd_a[k] = 1'b0; wr_a[k] = 1'b0;
        #1;
        if (drain) begin
            n = 0;
            while (qsize(k) != 0 && n < 40) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk($sformatf("resp_timeout[%0d]", k), 32'(qsize(k)), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rnd;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            addr_a[k] = '0; wdat_a[k] = '0; mask_a[k] = '0; wr_a[k] = 1'b0; rd_a[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_valid[%0d]", k), {31'd0, valid_a[k]}, 32'd0);
            chk($sformatf("reset_data[%0d]", k), rdat_a[k], 32'h0);
            chk($sformatf("reset_err[%0d]", k), {31'd0, err_a[k]}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready_after_reset[%0d]", k), {31'd0, ready_a[k]}, 32'd1);
        end

        for (int k = 0; k < 2; k++) begin
            txn(k, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
            txn(k, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0,        1'b1, 1'b1);
            txn(k, 1'b0, 1'b1, 32'h10, 4'hF, 32'h0,        1'b1, 1'b1);
            txn(k, 1'b0, 1'b1, 32'h12, 4'b0100, 32'h00AB0000, 1'b1, 1'b1);
            txn(k, 1'b1, 1'b0, 32'h13, 4'h5, 32'h0,        1'b1, 1'b1);
            txn(k, 1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1, 1'b1);
            txn(k, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0,        1'b1, 1'b1);
            txn(k, 1'b0, 1'b1, 32'h0,  4'hF, 32'hCAFEF00D, 1'b1, 1'b1);
            txn(k, 1'b0, 1'b1, 32'h4,  4'hF, 32'h01020304, 1'b1, 1'b1);
            txn(k, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0,      1'b1, 1'b1);
            txn(k, 1'b0, 1'b1, 32'h1004, 4'b0011, 32'hA5A5A5A5, 1'b1, 1'b1);
            txn(k, 1'b1, 1'b0, 32'h4,  4'hF, 32'h0,        1'b1, 1'b1);
            for (int i = 16; i < 32; i++) begin
                rnd = $urandom;
                txn(k, 1'b0, 1'b1, 32'(i * 4), 4'hF, rnd, 1'b1, 1'b1);
            end
            for (int j = 0; j < 12; j++) begin
                rnd = $urandom;
                txn(k, 1'b0, 1'b1, 32'((16 + $urandom_range(15)) * 4),
                    4'($urandom_range(15)), rnd, 1'b1, 1'b1);
            end
            for (int i = 16; i < 32; i++) begin
                txn(k, 1'b1, 1'b0, 32'(i * 4), 4'hF, 32'h0, 1'b1, 1'b1);
            end
        end

        // A request presented while the one-wait-state instance is busy must be dropped.
        txn(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 1'b0);
        chk("ready_in_wait", {31'd0, ready_a[1]}, 32'd0);
        addr_a[1] = 32'h10; wdat_a[1] = 32'hFFFFFFFF; mask_a[1] = 4'hF; wr_a[1] = 1'b1;
        @(negedge clk);
        chk("ready_in_resp", {31'd0, ready_a[1]}, 32'd0);
        wr_a[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("single_pulse_drained", 32'(qsize(1)), 32'd0);
        txn(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 1'b1);

        // Reset during the wait state of a write: no pulse, memory unchanged.
        txn(1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h12345678, 1'b1, 1'b1);
        txn(1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h00000055, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", {31'd0, ready_a[1]}, 32'd1);
        chk("no_valid_after_abort", {31'd0, valid_a[1]}, 32'd0);
        repeat (3) @(negedge clk);
        txn(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 1'b1);
        txn(0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 1'b1);

        repeat (5) @(negedge clk);
        chk("final_sb0_empty", 32'(sb0.size()), 32'd0);
        chk("final_sb1_empty", 32'(sb1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
- REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of two.
- REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra wait cycles before a response (0..15).
- REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
- REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-005 SHALL have port ip_data_addr, input, 32: byte address from the processor.
- REQ-006 SHALL have port ip_data_wr, input, 1: write request.
- REQ-007 SHALL have port ip_data_mask, input, 4: byte-lane write enables; bit n covers bits [8n+7:8n].
- REQ-008 SHALL have port ip_data_from_proc, input, 32: write data, already lane-aligned by the processor.
- REQ-009 SHALL have port ip_data_rd, input, 1: read request.
- REQ-010 SHALL have port op_data_ready, output, 1: the block can accept a request this cycle.
- REQ-011 SHALL have port op_data_valid, output, 1: one-cycle response or completion pulse.
- REQ-012 SHALL have port op_data_to_proc, output, 32: read data, a full aligned word.
- REQ-013 SHALL have port op_data_err, output, 1: out-of-range access flag, qualified by op_data_valid.

Function
- REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP; op_data_ready SHALL be 1 only in IDLE.
- REQ-015 SHALL accept a request in IDLE when ip_data_rd or ip_data_wr is 1, and latch the address, mask, data and operation.
- REQ-016 SHALL treat a request with rd and wr both at 1 as a write only.
- REQ-017 SHALL, on acceptance, load the wait counter with WAIT_CYCLES and go to WAIT, or go directly to RESP if WAIT_CYCLES is 0.
- REQ-018 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the cycle the counter reaches 0.
- REQ-019 SHALL give a total latency of 1+WAIT_CYCLES cycles from acceptance at cycle T to op_data_valid=1 at cycle T+1+WAIT_CYCLES.
- REQ-020 SHALL, in RESP, assert op_data_valid for exactly one cycle and then return to IDLE.
- REQ-021 SHALL, for a read in RESP, drive op_data_to_proc with mem[addr[31:2]] and ignore the mask and addr[1:0].
- REQ-022 SHALL, for a write, update only the enabled byte lanes of mem[addr[31:2]] at the RESP edge.
- REQ-023 SHALL make a write followed by a read of the same word return the new data.
- REQ-024 SHALL, for a write, drive op_data_to_proc to 0 in RESP.
- REQ-025 SHALL ignore requests presented outside IDLE; they are not queued.
- REQ-026 SHALL hold op_data_to_proc at 0 whenever op_data_valid is 0.
- REQ-027 SHALL allow back-to-back requests: a new request is accepted in the IDLE cycle after RESP.

Reset
- REQ-028 SHALL, on reset, set the state to IDLE, the counter to 0, op_data_valid to 0, op_data_to_proc to 0 and op_data_err to 0; op_data_ready SHALL read 1 on the cycle after reset.
- REQ-029 SHALL abort any in-flight request on reset mid-operation, with no memory write and no response.
- REQ-030 SHALL NOT reset the memory contents; they are undefined until written.

Configuration
- REQ-031 SHALL, when macro DMEM_BOUNDS_CHECK_EN is defined, treat a word index >= DEPTH_WORDS as out of range: writes are suppressed, reads return 0, and op_data_err=1 together with op_data_valid.
- REQ-032 SHALL, when DMEM_BOUNDS_CHECK_EN is undefined, wrap the word index modulo DEPTH_WORDS and tie op_data_err to 0.

Structure
- REQ-033 SHALL place the FSM state type, the byte-mask constants (word, half-low, half-high, each byte) and the counter width in the shared package salaga_mem_pkg.
- REQ-034 SHALL instantiate one sub-module, dmem_bram: a single-port, byte-write-enable, synchronous-read RAM; the FSM, counter and bounds logic SHALL stay in dmem_responder.

Verification
- REQ-035 SHALL cover: WAIT_CYCLES=1, write 0xDEADBEEF to 0x10 with mask 1111, then read 0x10 -> op_data_valid 2 cycles after each acceptance, read data 0xDEADBEEF.
- REQ-036 SHALL cover: memory word 0x00000000, write 0x00AB0000 to 0x12 with mask 0100, then read 0x10 -> read data 0x00AB0000.
- REQ-037 SHALL cover: WAIT_CYCLES=0, rd and wr both 1 with data 0x11223344 at 0x20 -> treated as a write, valid at T+1, a later read returns 0x11223344.
- REQ-038 SHALL cover: a second request during WAIT -> ignored, op_data_ready=0, exactly one valid pulse.
- REQ-039 SHALL cover: reset asserted during WAIT of a write of 0x55 to 0x40 -> no valid pulse, memory word unchanged.
- REQ-040 SHALL cover: with DMEM_BOUNDS_CHECK_EN and DEPTH_WORDS=1024, a read of 0x1000 -> valid=1, err=1, data 0; without the macro -> data equals the word at 0x0.
